// File: rtl/fetch_unit_if.sv
// Instruction-memory port and decode-side handshake of the fetch unit.
// The fetch unit drives the master side; ROM and decode sit on the slave side.
interface fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req;
   logic [DATA_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic [ADDR_W-1:0] out_pc_plus4;

   modport master (
      output imem_addr, imem_req,
      input  imem_rdata,
      output out_valid, out_inst, out_pc, out_pc_plus4,
      input  out_ready
   );

   modport slave (
      input  imem_addr, imem_req,
      output imem_rdata,
      input  out_valid, out_inst, out_pc, out_pc_plus4,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-throttled sequential fetch from a one-cycle ROM
// into a small prefetch FIFO, with flush-and-refetch on redirect.
module fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
   parameter int                DEPTH    = 4,
   localparam int               PW       = $clog2(DEPTH),
   localparam int               CW       = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   fetch_unit_if.master      bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [CW-1:0]     fifo_count
);

   typedef struct packed {
      logic [DATA_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] pc4;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   entry_t            hold_q, hold_d;
   entry_t            head_entry, shown;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW:0]       occupancy;
   logic              not_empty, pop, push, req;

   // A request is only issued when its response is guaranteed a free slot,
   // counting the one already in flight and the slot freed by this cycle's pop.
   always_comb begin
      not_empty  = (count_q != '0);
      head_entry = mem_q[head_q];
      pop        = not_empty && bus.out_ready && !redirect_valid;
      push       = inflight_q && !redirect_valid;
      occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      req        = reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = req;
      inflight_pc_d = fetch_pc_q;
      mem_d         = mem_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q + CW'(push) - CW'(pop);
      hold_d        = not_empty ? head_entry : hold_q;

      if (req) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (push) begin
         mem_d[tail_q] = {bus.imem_rdata, inflight_pc_q, inflight_pc_q + ADDR_W'(4)};
         tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~ADDR_W'(3);
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         hold_q        <= '0;
         mem_q         <= '{default: '0};
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         hold_q        <= hold_d;
         mem_q         <= mem_d;
      end
   end

   // While empty the outputs keep showing the last head entry instead of a stale slot.
   assign shown            = not_empty ? head_entry : hold_q;
   assign bus.imem_addr    = fetch_pc_q;
   assign bus.imem_req     = req;
   assign bus.out_valid    = not_empty;
   assign bus.out_inst     = shown.inst;
   assign bus.out_pc       = shown.pc;
   assign bus.out_pc_plus4 = shown.pc4;
   assign fifo_count       = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven redirect vectors plus hand-written
// sequences, with a scoreboard of expected fetch addresses checked on every pop.
module tb_fetch_unit;

   localparam int          ADDR_W  = 32;
   localparam int          DATA_W  = 32;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] BOOT_PC = 32'h0040_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  fifo_count;
   logic        wrap_redirect_valid;
   logic [31:0] wrap_redirect_pc;
   logic [2:0]  wrap_fifo_count;

   fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wrap_bus ();

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(BOOT_PC), .DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fifo_count     (fifo_count)
   );

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
      .clock          (clock),
      .reset          (reset),
      .bus            (wrap_bus),
      .redirect_valid (wrap_redirect_valid),
      .redirect_pc    (wrap_redirect_pc),
      .fifo_count     (wrap_fifo_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] target;
      logic [31:0] exp_pc;
   } redir_vec_t;

   int          checks = 0;
   int          failures = 0;
   int          consumed = 0;
   int          wrap_seen = 0;
   logic [31:0] exp_q[$];
   bit          sb_on = 1'b0;
   logic        req_seen = 1'b0;
   logic [31:0] addr_seen = '0;
   logic        wrap_req_seen = 1'b0;
   logic [31:0] wrap_addr_seen = '0;

   // ROM contents are tagged by address so a wrong or stale word is obvious.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'h3C3C_A5A5;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   task automatic start_stream(input logic [31:0] pc);
      exp_q.delete();
      exp_q.push_back(pc);
      sb_on = 1'b1;
   endtask

   // One clock cycle: answer last cycle's ROM request, drive inputs, then sample
   // mid-cycle and score any instruction the decoder takes this cycle.
   task automatic applyStimulus(input logic rst_v, input logic ready, input logic redir_v,
                                input logic [31:0] redir_pc);
      logic [31:0] exp_pc;
      @(negedge clock);
      bus.imem_rdata      = req_seen ? rom(addr_seen) : 32'hDEAD_BEEF;
      wrap_bus.imem_rdata = wrap_req_seen ? rom(wrap_addr_seen) : 32'hDEAD_BEEF;
      reset          = rst_v;
      bus.out_ready  = ready;
      redirect_valid = redir_v;
      redirect_pc    = redir_pc;
      #1;
      req_seen       = bus.imem_req;
      addr_seen      = bus.imem_addr;
      wrap_req_seen  = wrap_bus.imem_req;
      wrap_addr_seen = wrap_bus.imem_addr;
      if (sb_on && rst_v && !redir_v && bus.out_valid && ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
         end else begin
            exp_pc = exp_q.pop_front();
            exp_q.push_back(exp_pc + 32'd4);
            checkOutput("sb_out_pc", bus.out_pc, exp_pc);
            checkOutput("sb_out_inst", bus.out_inst, rom(exp_pc));
            checkOutput("sb_out_pc_plus4", bus.out_pc_plus4, exp_pc + 32'd4);
         end
         consumed++;
      end
      if (redir_v) begin
         start_stream(redir_pc & ~32'h3);
      end
      if (rst_v && wrap_bus.out_valid && wrap_seen < 2) begin
         exp_pc = (wrap_seen == 0) ? WRAP_PC : 32'h0000_0000;
         checkOutput("wrap_out_pc", wrap_bus.out_pc, exp_pc);
         checkOutput("wrap_out_inst", wrap_bus.out_inst, rom(exp_pc));
         checkOutput("wrap_out_pc_plus4", wrap_bus.out_pc_plus4, exp_pc + 32'd4);
         wrap_seen++;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      redir_vec_t vecs[4];
      int         snap;
      bit         rdy;

      vecs[0] = '{32'h0040_0100, 32'h0040_0100};
      vecs[1] = '{32'h0040_0103, 32'h0040_0100};
      vecs[2] = '{32'h0040_0206, 32'h0040_0204};
      vecs[3] = '{32'h0040_FFF9, 32'h0040_FFF8};

      reset               = 1'b0;
      redirect_valid      = 1'b0;
      redirect_pc         = '0;
      bus.out_ready       = 1'b1;
      bus.imem_rdata      = '0;
      wrap_bus.out_ready  = 1'b1;
      wrap_bus.imem_rdata = '0;
      wrap_redirect_valid = 1'b0;
      wrap_redirect_pc    = '0;

      // Reset state.
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_imem_req", bus.imem_req, 0);
      checkOutput("rst_imem_addr", bus.imem_addr, BOOT_PC);
      checkOutput("rst_out_pc", bus.out_pc, 0);
      checkOutput("rst_out_inst", bus.out_inst, 0);
      checkOutput("rst_out_pc_plus4", bus.out_pc_plus4, 0);
      checkOutput("rst_fifo_count", fifo_count, 0);
      checkOutput("wrap_rst_fifo_count", wrap_fifo_count, 0);

      // Release: request in cycle 0, first instruction visible in cycle 2, then one per cycle.
      start_stream(BOOT_PC);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("c0_imem_req", bus.imem_req, 1);
      checkOutput("c0_imem_addr", bus.imem_addr, BOOT_PC);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("c1_out_valid", bus.out_valid, 0);
      checkOutput("c1_imem_addr", bus.imem_addr, BOOT_PC + 32'd4);
      consumed = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("stream_valid", bus.out_valid, 1);
      end
      checkOutput("stream_consumed", consumed, 12);

      // Back-pressure: buffer fills to DEPTH and fetching stops, nothing lost on release.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, '0);
         checkOutput("stall_count_bound", fifo_count <= 3'd4, 1);
      end
      checkOutput("stall_count_full", fifo_count, 4);
      checkOutput("stall_req_off", bus.imem_req, 0);
      consumed = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("unstall_valid", bus.out_valid, 1);
      end
      checkOutput("unstall_consumed", consumed, 12);

      // Redirect vectors with a request in flight.
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
         applyStimulus(1'b1, 1'b1, 1'b1, vecs[v].target);
         checkOutput("redir_req_low", bus.imem_req, 0);
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("redir_t1_valid", bus.out_valid, 0);
         checkOutput("redir_t1_count", fifo_count, 0);
         checkOutput("redir_t1_addr", bus.imem_addr, vecs[v].exp_pc);
         checkOutput("redir_t1_req", bus.imem_req, 1);
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("redir_t2_valid", bus.out_valid, 0);
         snap = consumed;
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("redir_t3_valid", bus.out_valid, 1);
         checkOutput("redir_t3_pc", bus.out_pc, vecs[v].exp_pc);
         checkOutput("redir_t3_pop", consumed, snap + 1);
      end

      // Back-to-back redirects: only the second target may appear.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0800);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0A00);
      checkOutput("dbl_req_low", bus.imem_req, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("dbl_t2_valid", bus.out_valid, 0);
      checkOutput("dbl_t2_addr", bus.imem_addr, 32'h0040_0A00);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("dbl_t3_valid", bus.out_valid, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("dbl_t4_valid", bus.out_valid, 1);
      checkOutput("dbl_t4_pc", bus.out_pc, 32'h0040_0A00);

      // Random back-pressure; the scoreboard catches any loss or duplication.
      for (int i = 0; i < 40; i++) begin
         rdy = 1'($urandom_range(0, 1));
         applyStimulus(1'b1, rdy, 1'b0, '0);
         checkOutput("rand_count_bound", fifo_count <= 3'd4, 1);
      end

      // Reset with a full buffer clears everything at once, then restarts at the boot PC.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
      checkOutput("pre_rst_full", fifo_count, 4);
      sb_on = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("mid_rst_valid", bus.out_valid, 0);
      checkOutput("mid_rst_pc", bus.out_pc, 0);
      checkOutput("mid_rst_inst", bus.out_inst, 0);
      checkOutput("mid_rst_pc_plus4", bus.out_pc_plus4, 0);
      checkOutput("mid_rst_count", fifo_count, 0);
      checkOutput("mid_rst_req", bus.imem_req, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      start_stream(BOOT_PC);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("rerun_c0_addr", bus.imem_addr, BOOT_PC);
      checkOutput("rerun_c0_req", bus.imem_req, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("rerun_c1_valid", bus.out_valid, 0);
      consumed = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         checkOutput("rerun_valid", bus.out_valid, 1);
      end
      checkOutput("rerun_consumed", consumed, 6);

      checkOutput("wrap_instructions_seen", wrap_seen, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
